// File: rtl/lsu_mem_port.sv
// Load/store adapter driving one port of a byte-write block RAM with a
// two-edge read path (negedge array read, posedge output register).
// One request in flight; responses are single-cycle pulses without backpressure.
module lsu_mem_port #(
   parameter int unsigned RAM_DEPTH  = 1024,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [31:0]           req_addr_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  resp_valid_o,
   output logic [31:0]           resp_rdata_o,
   output logic                  resp_misaligned_o,
   output logic                  resp_oob_o,
   output logic                  mem_en_o,
   output logic [3:0]            mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_din_o,
   output logic                  mem_regce_o,
   output logic                  mem_rst_o,
   input  logic [31:0]           mem_dout_i
);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapture, StResp} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH+1:0]   addr_q;
   logic [1:0]              size_q;
   logic                    we_q;
   logic                    uns_q;
   logic [31:0]             wdata_q;
   logic [31:0]             rdata_q;
   logic                    misal_q;
   logic                    oob_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;

   logic                    accept;
   logic                    req_misal;
   logic                    req_oob;
   logic                    issue;
   logic [3:0]              lane_we;
   logic [31:0]             lane_din;
   logic [31:0]             load_ext;

   assign req_ready_o = (state_q == StIdle);
   assign accept      = req_valid_i & req_ready_o;
   assign issue       = (state_q == StIssue);

   // Request legality, evaluated on the raw inputs so errors skip the RAM entirely.
   always_comb begin
      req_misal = 1'b0;
      unique case (req_size_i)
         2'b00:   req_misal = 1'b0;
         2'b01:   req_misal = req_addr_i[0];
         2'b10:   req_misal = |req_addr_i[1:0];
         default: req_misal = 1'b1;
      endcase
      req_oob = ({2'b00, req_addr_i[31:2]} >= 32'(RAM_DEPTH));
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (req_valid_i) state_d = (req_misal | req_oob) ? StResp : StIssue;
         StIssue:   state_d = we_q ? StResp : StWait;
         StWait:    state_d = StCapture;
         StCapture: state_d = StResp;
         StResp:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Store lane enables and replicated write data from the byte offset.
   always_comb begin
      lane_we  = 4'b0000;
      lane_din = 32'h0;
      unique case (size_q)
         2'b00: begin
            lane_we  = 4'b0001 << addr_q[1:0];
            lane_din = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            lane_we  = 4'b0011 << addr_q[1:0];
            lane_din = {2{wdata_q[15:0]}};
         end
         default: begin
            lane_we  = 4'b1111;
            lane_din = wdata_q;
         end
      endcase
   end

   // Load lane select plus sign/zero extension.
   always_comb begin
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      byte_sel = 8'h0;
      unique case (addr_q[1:0])
         2'd0:    byte_sel = mem_dout_i[7:0];
         2'd1:    byte_sel = mem_dout_i[15:8];
         2'd2:    byte_sel = mem_dout_i[23:16];
         default: byte_sel = mem_dout_i[31:24];
      endcase
      half_sel = addr_q[1] ? mem_dout_i[31:16] : mem_dout_i[15:0];
      load_ext = mem_dout_i;
      unique case (size_q)
         2'b00:   load_ext = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
         2'b01:   load_ext = {{16{half_sel[15] & ~uns_q}}, half_sel};
         default: load_ext = mem_dout_i;
      endcase
   end

   // RAM port drive; strobes are decoded from state so reset kills them at once.
   always_comb begin
      mem_en_o    = issue;
      mem_we_o    = (issue & we_q) ? lane_we : 4'b0000;
      mem_din_o   = (issue & we_q) ? lane_din : 32'h0;
      mem_addr_o  = issue ? addr_q[ADDR_WIDTH+1:2] : mem_addr_q;
      mem_regce_o = (state_q == StWait);
      mem_rst_o   = ~rst_ni;
   end

   assign resp_valid_o      = (state_q == StResp);
   assign resp_rdata_o      = rdata_q;
   assign resp_misaligned_o = misal_q;
   assign resp_oob_o        = oob_q;

   // State, request capture and response registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         size_q     <= 2'b00;
         we_q       <= 1'b0;
         uns_q      <= 1'b0;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
         misal_q    <= 1'b0;
         oob_q      <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= req_addr_i[ADDR_WIDTH+1:0];
            size_q  <= req_size_i;
            we_q    <= req_we_i;
            uns_q   <= req_unsigned_i;
            wdata_q <= req_wdata_i;
            rdata_q <= 32'h0;
            misal_q <= req_misal;
            oob_q   <= req_oob;
         end else if (state_q == StCapture) begin
            rdata_q <= load_ext;
         end
         if (issue) mem_addr_q <= addr_q[ADDR_WIDTH+1:2];
      end
   end

endmodule
